// File: rtl/alu_mdu.sv
// Single-issue ALU plus iterative multiply/divide unit with a valid/ready handshake.
// ALU ops and divide special cases finish in one cycle; multiply and divide take XLEN iterations.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [4:0] {
    OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR  = 5'd3,
    OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7,
    OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_PASS = 5'd10,
    OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
    OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23
  } op_e;

  state_t              state;
  logic [2:0]          mop_q;
  logic [2*XLEN-1:0]   acc;      // multiply: {partial high, multiplier}; divide: {remainder, quotient}
  logic [XLEN-1:0]     mcand;    // multiplicand or divisor magnitude
  logic                neg_q;
  logic                rneg_q;
  logic [CW-1:0]       cnt;

  logic                accept, is_mdu, is_div, div_zero, div_ovf;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag, alu_res, mdu_res;
  logic [XLEN:0]       mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0]   acc_nxt, prod;

  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready;

  assign is_mdu   = (op[4:3] == 2'b10);
  assign is_div   = is_mdu && op[2];
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);

  // Single-cycle results, including the divide corner cases that bypass iteration.
  always_comb begin
    // NOTE: default assignment first so every path drives alu_res and no latch is inferred.
    alu_res = a;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_SRA:  alu_res = $signed(a) >>> b[SHW-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : a;
      OP_REM, OP_REMU: alu_res = div_zero ? a : '0;
      default: alu_res = a;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, mcand} & {(XLEN+1){acc[0]}});
    div_rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_rs - {1'b0, mcand};
    if (!mop_q[2])
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {div_rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    case (mop_q)
      3'b000:               mdu_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:       mdu_res = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      default:              mdu_res = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      mop_q     <= '0;
      acc       <= '0;
      mcand     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mop_q <= op[2:0];
          if (is_mdu && !div_zero && !div_ovf) begin
            acc    <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            mcand  <= is_div ? b_mag : a_mag;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt    <= '0;
            state  <= CALC;
          end else begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            result    <= mdu_res;
            zero      <= (mdu_res == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
